// File: rtl/la_i2c_device_pkg.sv
// Shared types and constants for the I2C target engine: FSM encoding,
// ACK/RW bit values and small state-mapping helpers.
`timescale 1ns/1ps
package la_i2c_device_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_RW_READ = 1'b1;

  // ACK phase that follows a completed byte in each receive state
  function automatic i2c_state_e ack_state(input i2c_state_e s);
    case (s)
      ST_ADDR: ack_state = ST_ADDR_ACK;
      ST_PTR:  ack_state = ST_PTR_ACK;
      default: ack_state = ST_WDATA_ACK;
    endcase
  endfunction

  // Busy once the address has matched; the address phase itself is not busy
  function automatic logic state_busy(input i2c_state_e s);
    case (s)
      ST_IDLE, ST_ADDR, ST_IGNORE: state_busy = 1'b0;
      default:                     state_busy = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/la_i2c_device_sync.sv
// Two-flop synchronizer for SCL/SDA plus registered rise/fall/START/STOP pulses.
// An SDA change while SCL is itself changing is never reported as START/STOP.
`timescale 1ns/1ps
module la_i2c_device_sync #(
  parameter string TARGET = "DEFAULT"
) (
  input  logic clk,
  input  logic nreset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_level
);

  logic [1:0] scl_pipe_r, sda_pipe_r;
  logic       scl_prev_r, sda_prev_r;
  logic       scl_rise_r, scl_fall_r, start_r, stop_r, sda_level_r;

  generate
    if (TARGET == "DEFAULT") begin : g_generic
      // Generic synchronizer flops, reset to the idle-high bus level
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          scl_pipe_r <= 2'b11;
          sda_pipe_r <= 2'b11;
        end else begin
          scl_pipe_r <= {scl_pipe_r[0], scl_in};
          sda_pipe_r <= {sda_pipe_r[0], sda_in};
        end
      end
    end else begin : g_tech
      // Technology synchronizer cells map onto this chain
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          scl_pipe_r <= 2'b11;
          sda_pipe_r <= 2'b11;
        end else begin
          scl_pipe_r <= {scl_pipe_r[0], scl_in};
          sda_pipe_r <= {sda_pipe_r[0], sda_in};
        end
      end
    end
  endgenerate

  // Edge and bus-condition detection on the synchronized levels
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      scl_prev_r  <= 1'b1;
      sda_prev_r  <= 1'b1;
      scl_rise_r  <= 1'b0;
      scl_fall_r  <= 1'b0;
      start_r     <= 1'b0;
      stop_r      <= 1'b0;
      sda_level_r <= 1'b1;
    end else begin
      scl_prev_r  <= scl_pipe_r[1];
      sda_prev_r  <= sda_pipe_r[1];
      scl_rise_r  <= scl_pipe_r[1] & ~scl_prev_r;
      scl_fall_r  <= ~scl_pipe_r[1] & scl_prev_r;
      start_r     <= scl_pipe_r[1] & scl_prev_r & sda_prev_r & ~sda_pipe_r[1];
      stop_r      <= scl_pipe_r[1] & scl_prev_r & ~sda_prev_r & sda_pipe_r[1];
      sda_level_r <= sda_pipe_r[1];
    end
  end

  assign scl_rise  = scl_rise_r;
  assign scl_fall  = scl_fall_r;
  assign start     = start_r;
  assign stop      = stop_r;
  assign sda_level = sda_level_r;

endmodule

// File: rtl/la_i2c_device.sv
// I2C target engine: address match, register pointer, auto-incrementing
// byte-wide register port for writes and reads.
`timescale 1ns/1ps
module la_i2c_device
  import la_i2c_device_pkg::*;
#(
  parameter string      TARGET = "DEFAULT",
  parameter logic [6:0] ADDR   = 7'h50
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       i2c_scl_in,
  input  logic       i2c_sda_in,
  output logic       i2c_scl_out,
  output logic       i2c_scl_oe,
  output logic       i2c_sda_out,
  output logic       i2c_sda_oe,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;

  la_i2c_device_sync #(.TARGET(TARGET)) u_sync (
    .clk      (clk),
    .nreset   (nreset),
    .scl_in   (i2c_scl_in),
    .sda_in   (i2c_sda_in),
    .scl_rise (scl_rise_s),
    .scl_fall (scl_fall_s),
    .start    (start_s),
    .stop     (stop_s),
    .sda_level(sda_s)
  );

  i2c_state_e state_r, state_s;
  logic [2:0] bit_cnt_r, cnt_s;
  logic [7:0] shift_r, shift_s, ptr_r, ptr_s, wdata_r, wdata_s, addr_r, byte_s;
  logic       full_r, full_s, rw_r, rw_s, rd_pend_r, rd_pend_s;
  logic       sda_oe_r, sda_oe_s, wr_en_r, wr_en_s, rd_en_r, rd_en_s, busy_r;

  assign byte_s = {shift_r[6:0], sda_s};

  // full_r marks a received byte awaiting the SCL fall that opens its ACK bit
  always_comb begin
    state_s   = state_r;
    cnt_s     = bit_cnt_r;
    shift_s   = shift_r;
    ptr_s     = ptr_r;
    full_s    = full_r;
    rw_s      = rw_r;
    rd_pend_s = rd_en_r;
    sda_oe_s  = sda_oe_r;
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    wdata_s   = wdata_r;
    if (start_s || stop_s) begin
      state_s   = start_s ? ST_ADDR : ST_IDLE;
      cnt_s     = 3'd0;
      full_s    = 1'b0;
      sda_oe_s  = 1'b0;
      rd_pend_s = 1'b0;
    end else begin
      case (state_r)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s && !full_r) begin
            shift_s = byte_s;
            cnt_s   = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              full_s = 1'b1;
              case (state_r)
                ST_ADDR: begin
                  rw_s    = byte_s[0];
                  state_s = (byte_s[7:1] == ADDR) ? ST_ADDR : ST_IGNORE;
                end
                ST_PTR:  ptr_s = byte_s;
                default: begin
                  wr_en_s = 1'b1;
                  wdata_s = byte_s;
                  ptr_s   = ptr_r + 8'd1;
                end
              endcase
            end else begin
              full_s = 1'b0;
            end
          end else if (scl_fall_s && full_r) begin
            full_s   = 1'b0;
            sda_oe_s = 1'b1;
            state_s  = ack_state(state_r);
          end else begin
            full_s = full_r;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_s = 1'b0;
            if (state_r == ST_ADDR_ACK && rw_r == I2C_RW_READ) begin
              state_s = ST_RDATA;
              rd_en_s = 1'b1;
            end else if (state_r == ST_ADDR_ACK) begin
              state_s = ST_PTR;
            end else begin
              state_s = ST_WDATA;
            end
          end else begin
            sda_oe_s = 1'b1;
          end
        end
        ST_RDATA: begin
          if (rd_pend_r) begin
            shift_s  = reg_rdata;
            sda_oe_s = ~reg_rdata[7];
            ptr_s    = ptr_r + 8'd1;
            cnt_s    = 3'd0;
          end else if (scl_fall_s && bit_cnt_r == 3'd7) begin
            sda_oe_s = 1'b0;
            cnt_s    = 3'd0;
            state_s  = ST_RDATA_ACK;
          end else if (scl_fall_s) begin
            shift_s  = {shift_r[6:0], 1'b0};
            sda_oe_s = ~shift_r[6];
            cnt_s    = bit_cnt_r + 3'd1;
          end else begin
            sda_oe_s = sda_oe_r;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_s) begin
            if (sda_s == I2C_ACK) begin
              full_s = 1'b1;
            end else begin
              state_s = ST_IGNORE;
            end
          end else if (scl_fall_s && full_r) begin
            full_s  = 1'b0;
            state_s = ST_RDATA;
            rd_en_s = 1'b1;
          end else begin
            full_s = full_r;
          end
        end
        ST_IDLE, ST_IGNORE: sda_oe_s = 1'b0;
        default:            state_s  = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reg_addr trails the pointer by one clock
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      ptr_r     <= 8'd0;
      full_r    <= 1'b0;
      rw_r      <= 1'b0;
      rd_pend_r <= 1'b0;
      sda_oe_r  <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      wdata_r   <= 8'd0;
      addr_r    <= 8'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= cnt_s;
      shift_r   <= shift_s;
      ptr_r     <= ptr_s;
      full_r    <= full_s;
      rw_r      <= rw_s;
      rd_pend_r <= rd_pend_s;
      sda_oe_r  <= sda_oe_s;
      wr_en_r   <= wr_en_s;
      rd_en_r   <= rd_en_s;
      wdata_r   <= wdata_s;
      addr_r    <= ptr_r;
      busy_r    <= state_busy(state_s);
    end
  end

  assign i2c_scl_out = 1'b0;
  assign i2c_scl_oe  = 1'b0;
  assign i2c_sda_out = 1'b0;
  assign i2c_sda_oe  = sda_oe_r;
  assign reg_wr_en   = wr_en_r;
  assign reg_rd_en   = rd_en_r;
  assign reg_addr    = addr_r;
  assign reg_wdata   = wdata_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_la_i2c_device.sv
// Directed bench for la_i2c_device: bit-banged I2C host on a wired-AND SDA,
// register-file model with one-clock read latency, strobe logs.
`timescale 1ns/1ps
module tb_la_i2c_device;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       scl_host = 1'b1, sda_host = 1'b1;
  logic       i2c_scl_out, i2c_scl_oe, i2c_sda_out, i2c_sda_oe;
  logic       reg_wr_en, reg_rd_en, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       sda_bus;
  logic [7:0] mem [256];
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  int oe_cnt = 0, busy_cnt = 0;
  int errors = 0, checks = 0;

  assign sda_bus = sda_host & ~i2c_sda_oe;

  always #5 clk = ~clk;

  la_i2c_device #(.TARGET("DEFAULT"), .ADDR(7'h50)) dut (
    .clk(clk), .nreset(nreset),
    .i2c_scl_in(scl_host), .i2c_sda_in(sda_bus),
    .i2c_scl_out(i2c_scl_out), .i2c_scl_oe(i2c_scl_oe),
    .i2c_sda_out(i2c_sda_out), .i2c_sda_oe(i2c_sda_oe),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy)
  );

  // Register-file model and strobe monitor
  always @(negedge clk) begin
    if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_rd_en) begin
      rd_log.push_back(reg_addr);
      reg_rdata = mem[reg_addr];
    end
    if (i2c_sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic q_wait();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_host = 1'b1; q_wait();
    scl_host = 1'b1; q_wait();
    sda_host = 1'b0; q_wait();
    scl_host = 1'b0; q_wait();
  endtask

  task automatic bus_stop();
    sda_host = 1'b0; q_wait();
    scl_host = 1'b1; q_wait();
    sda_host = 1'b1; q_wait(); q_wait();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_host = b[i]; q_wait();
      scl_host = 1'b1; q_wait(); q_wait();
      scl_host = 1'b0; q_wait();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_host = 1'b1; q_wait();
    scl_host = 1'b1; q_wait();
    ack = ~sda_bus; q_wait();
    scl_host = 1'b0; q_wait();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    sda_host = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q_wait();
      scl_host = 1'b1; q_wait();
      b[i] = sda_bus; q_wait();
      scl_host = 1'b0; q_wait();
    end
    sda_host = nack; q_wait();
    scl_host = 1'b1; q_wait(); q_wait();
    scl_host = 1'b0; q_wait();
    sda_host = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i2c_scl_out, i2c_scl_oe, i2c_sda_out, i2c_sda_oe, reg_wr_en, reg_rd_en, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000000",
        {i2c_scl_out, i2c_scl_oe, i2c_sda_out, i2c_sda_oe, reg_wr_en, reg_rd_en, busy});
    end
    checks++;
    if ({reg_addr, reg_wdata} !== 16'h0000) begin
      errors++; $display("FAIL reset_data got=%h exp=0000", {reg_addr, reg_wdata});
    end
    nreset = 1'b1; q_wait();
    checks++;
    if ({i2c_sda_oe, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_release got=%b exp=00", {i2c_sda_oe, busy});
    end
  endtask

  task automatic test_write();
    logic [3:0] acks;
    int base;
    base = wr_log.size();
    bus_start();
    send_byte(8'hA0, acks[3]);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got=%b exp=1", busy); end
    send_byte(8'h10, acks[2]);
    send_byte(8'h5A, acks[1]);
    send_byte(8'hC3, acks[0]);
    bus_stop();
    checks++;
    if (acks !== 4'b1111) begin errors++; $display("FAIL write_acks got=%b exp=1111", acks); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
    checks++;
    if (wr_log.size() - base !== 2) begin
      errors++; $display("FAIL write_count got=%0d exp=2", wr_log.size() - base);
    end else begin
      checks++;
      if (wr_log[base] !== 16'h105A) begin errors++; $display("FAIL write_0 got=%h exp=105a", wr_log[base]); end
      checks++;
      if (wr_log[base+1] !== 16'h11C3) begin errors++; $display("FAIL write_1 got=%h exp=11c3", wr_log[base+1]); end
    end
  endtask

  task automatic test_read();
    logic [2:0] acks;
    logic [7:0] b0, b1;
    int rbase, wbase;
    rbase = rd_log.size(); wbase = wr_log.size();
    mem[8'h20] = 8'h96; mem[8'h21] = 8'h3C;
    bus_start();
    send_byte(8'hA0, acks[2]);
    send_byte(8'h20, acks[1]);
    bus_start();
    send_byte(8'hA1, acks[0]);
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_nack_busy got=%b exp=0", busy); end
    bus_stop();
    checks++;
    if (acks !== 3'b111) begin errors++; $display("FAIL read_acks got=%b exp=111", acks); end
    checks++;
    if (b0 !== 8'h96) begin errors++; $display("FAIL read_byte0 got=%h exp=96", b0); end
    checks++;
    if (b1 !== 8'h3C) begin errors++; $display("FAIL read_byte1 got=%h exp=3c", b1); end
    checks++;
    if (wr_log.size() !== wbase) begin errors++; $display("FAIL read_no_wr got=%0d exp=%0d", wr_log.size(), wbase); end
    checks++;
    if (rd_log.size() - rbase !== 2) begin
      errors++; $display("FAIL read_count got=%0d exp=2", rd_log.size() - rbase);
    end else begin
      checks++;
      if ({rd_log[rbase], rd_log[rbase+1]} !== 16'h2021) begin
        errors++; $display("FAIL read_addrs got=%h exp=2021", {rd_log[rbase], rd_log[rbase+1]});
      end
    end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int oe0, busy0, wb, rb;
    oe0 = oe_cnt; busy0 = busy_cnt; wb = wr_log.size(); rb = rd_log.size();
    bus_start();
    send_byte(8'hB0, a0);
    send_byte(8'h11, a1);
    bus_stop();
    checks++;
    if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL mismatch_ack got=%b exp=00", {a0, a1}); end
    checks++;
    if (oe_cnt !== oe0) begin errors++; $display("FAIL mismatch_oe got=%0d exp=%0d", oe_cnt, oe0); end
    checks++;
    if (busy_cnt !== busy0) begin errors++; $display("FAIL mismatch_busy got=%0d exp=%0d", busy_cnt, busy0); end
    checks++;
    if ({wr_log.size(), rd_log.size()} !== {wb, rb}) begin
      errors++; $display("FAIL mismatch_strobes got=%0d/%0d exp=%0d/%0d", wr_log.size(), rd_log.size(), wb, rb);
    end
  endtask

  task automatic test_ptr_wrap();
    logic ack;
    int base;
    base = wr_log.size();
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h01, ack);
    send_byte(8'h02, ack);
    bus_stop();
    checks++;
    if (wr_log.size() - base !== 2) begin
      errors++; $display("FAIL wrap_count got=%0d exp=2", wr_log.size() - base);
    end else begin
      checks++;
      if ({wr_log[base], wr_log[base+1]} !== 32'hFF01_0002) begin
        errors++; $display("FAIL wrap_strobes got=%h exp=ff010002", {wr_log[base], wr_log[base+1]});
      end
    end
  endtask

  task automatic test_stop_mid_byte();
    logic ack;
    int base;
    base = wr_log.size();
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    send_bits(8'hF0, 4);
    bus_stop();
    checks++;
    if (wr_log.size() !== base) begin errors++; $display("FAIL stopmid_no_wr got=%0d exp=%0d", wr_log.size(), base); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stopmid_busy got=%b exp=0", busy); end
    bus_start();
    send_byte(8'hA0, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL stopmid_reack got=%b exp=1", ack); end
    bus_stop();
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    mem[8'h40] = 8'h00;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    bus_start();
    send_byte(8'hA1, ack);
    q_wait(); scl_host = 1'b1; q_wait();
    checks++;
    if (i2c_sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_pre_oe got=%b exp=1", i2c_sda_oe); end
    @(negedge clk);
    nreset = 1'b0;
    #1;
    checks++;
    if (i2c_sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got=%b exp=0", i2c_sda_oe); end
    checks++;
    if ({reg_wr_en, reg_rd_en, busy, reg_addr, reg_wdata} !== 19'd0) begin
      errors++; $display("FAIL rstmid_outputs got=%h exp=0", {reg_wr_en, reg_rd_en, busy, reg_addr, reg_wdata});
    end
    sda_host = 1'b1; q_wait();
    nreset = 1'b1; q_wait();
    checks++;
    if ({busy, i2c_sda_oe} !== 2'b00) begin errors++; $display("FAIL rstmid_idle got=%b exp=00", {busy, i2c_sda_oe}); end
    bus_start();
    send_byte(8'hA0, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL rstmid_reack got=%b exp=1", ack); end
    bus_stop();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_ptr_wrap();
    test_stop_mid_byte();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
